if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch front end that generates the PC stream and issues word reads to the memory controller through its IF request port.
- Buffers returned instructions with their PCs in a small queue and presents them to decode with a valid/stall handshake.
- Handles branch/jump redirects, including discarding a read already in flight.
- Sits between the memory controller (downstream of its `data_o`/`done_o`) and the ID stage.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- DATA_W, 32, instruction width.
- QDEPTH, 2, instruction-queue entries (power of 2, ≥2).
- RESET_PC, 32'h0, PC after reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- rdy  in  1  global enable; when low, all state holds
- stall_i  in  1  ID cannot accept this cycle
- redirect_i  in  1  branch/jump taken; flush and restart
- redirect_pc_i  in  ADDR_W  new PC
- mem_req_i  in  1  MEM stage is requesting the controller this cycle (its read or write enable is nonzero)
- ctrl_busy_i  in  1  memory controller busy
- ctrl_done_i  in  1  one-cycle completion pulse
- ctrl_data_i  in  DATA_W  read data, valid with `ctrl_done_i`
- if_re_o  out  1  fetch read request
- if_addr_o  out  ADDR_W  fetch address
- id_valid_o  out  1  queue head valid
- id_pc_o  out  ADDR_W  PC of head
- id_inst_o  out  DATA_W  instruction of head

Behaviour:
Reset (rst=0, async):
- pc = RESET_PC, state = IDLE, queue empty, drop = 0.
- Outputs: `if_re_o` = 0, `if_addr_o` = RESET_PC, `id_valid_o` = 0, `id_pc_o` = 0, `id_inst_o` = 0.

States:
- IDLE: no request. Go to REQ when queue count < QDEPTH and no redirect this cycle.
- REQ: `if_re_o` = 1, `if_addr_o` = pc. The request is accepted in a cycle where `mem_req_i` = 0 and `ctrl_busy_i` = 0.
  - On accept: go to WAIT, latch req_pc = pc.
  - Otherwise: stay in REQ, holding the address.
- WAIT: `if_re_o` = 0. On `ctrl_done_i`:
  - if drop = 1: discard the data, clear drop, pc unchanged;
  - else: push {req_pc, `ctrl_data_i`} and set pc = req_pc + 4.
  - Then go to REQ if space remains after the push, else IDLE.

Ownership:
- `ctrl_done_i` is attributed to fetch only in WAIT.
- `ctrl_done_i` seen in IDLE or REQ belongs to MEM and is ignored.

Latency:
- Minimum accept-to-done is 1 cycle (controller cache hit).
- An entry pushed at edge T gives `id_valid_o` = 1 from T onward.

Queue:
- `id_*` outputs show the head.
- Pop at an edge where `id_valid_o` = 1 and `stall_i` = 0.
- Push and pop in the same cycle are allowed when full.
- Outputs hold while `stall_i` = 1.

Redirect (highest priority):
- Flush the queue (`id_valid_o` = 0 next cycle) and set pc = {redirect_pc_i[ADDR_W-1:2], 2'b00}.
- In REQ: go to IDLE; request again from the new pc next cycle.
- In WAIT: set drop = 1, stay in WAIT.
- Redirect coinciding with `ctrl_done_i` in WAIT: data is dropped, go to IDLE, new pc kept.
- Redirect overrides a same-cycle pop.

Arithmetic and misc:
- PC increments modulo 2^ADDR_W; 0xFFFFFFFC wraps to 0.
- `rdy` = 0: no state, pc, or queue change; outputs hold.
- Reset mid-read: the controller is reset by the same event; the fetch unit restarts from RESET_PC with no drop pending.

Optional Feature:
- IF_PERF_CNT_EN defined: adds outputs `perf_fetch_o` [31:0] and `perf_drop_o` [31:0].
  - `perf_fetch_o` counts pushes; `perf_drop_o` counts discarded completions.
  - Both reset to 0, saturate at 0xFFFFFFFF, and hold when `rdy` = 0.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package if_pkg:
  - state encoding localparams IDLE/REQ/WAIT, one-hot 3'b001/010/100;
  - INST_BYTES = 4;
  - default RESET_PC.
- Sub-module fetch_queue:
  - parameterised synchronous FIFO of {pc, inst} with push, pop, flush, count, full, empty.
  - flush has priority over push.

Test Plan:
1. Reset, `stall_i` = 0, controller returns done 1 cycle after each accept with data 0x00000013 → `id_pc_o` sequence 0x0, 0x4, 0x8, each with inst 0x00000013.
2. `stall_i` = 1 held → after 2 pushes `if_re_o` stays 0 and `id_pc_o` holds 0x0. Release → 0x4 then 0x8 fetched.
3. `mem_req_i` = 1 for 3 cycles while in REQ → `if_addr_o` held, no transition to WAIT, foreign `ctrl_done_i` ignored, no push.
4. Redirect to 0x103 while in WAIT, done arrives 4 cycles later with 0xDEADBEEF → data dropped, queue empty, next `if_addr_o` = 0x100.
5. Redirect in the same cycle as `ctrl_done_i` → no push, next request at the redirect PC. Redirect in REQ → `if_re_o` deasserts one cycle, then new address.
6. redirect_pc = 0xFFFFFFFC → fetches 0xFFFFFFFC then 0x00000000. Also toggle `rdy` = 0 mid-WAIT → state and outputs frozen.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// ============================================================================
// Module : if_pkg
// Brief  : Shared FSM encodings and constants for the instruction-fetch unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_pkg;

    localparam logic [2:0] IDLE = 3'b001;
    localparam logic [2:0] REQ  = 3'b010;
    localparam logic [2:0] WAIT = 3'b100;

    localparam int unsigned INST_BYTES       = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/if_fetch_if.sv
// ============================================================================
// Module : if_fetch_if
// Brief  : Fetch-side memory-controller bus plus the ID-stage handshake.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface if_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    logic              if_re_o;
    logic [ADDR_W-1:0] if_addr_o;
    logic              mem_req_i;
    logic              ctrl_busy_i;
    logic              ctrl_done_i;
    logic [DATA_W-1:0] ctrl_data_i;

    logic              stall_i;
    logic              id_valid_o;
    logic [ADDR_W-1:0] id_pc_o;
    logic [DATA_W-1:0] id_inst_o;

    modport master (
        output if_re_o, if_addr_o, id_valid_o, id_pc_o, id_inst_o,
        input  mem_req_i, ctrl_busy_i, ctrl_done_i, ctrl_data_i, stall_i
    );

    modport slave (
        input  if_re_o, if_addr_o, id_valid_o, id_pc_o, id_inst_o,
        output mem_req_i, ctrl_busy_i, ctrl_done_i, ctrl_data_i, stall_i
    );

endinterface

`default_nettype wire

// File: rtl/if_fetch_queue.sv
// ============================================================================
// Module : fetch_queue
// Brief  : Synchronous FIFO of {pc, inst}; flush wins over push.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] push_pc_i,
    input  logic [DATA_W-1:0] push_inst_i,
    output logic [ADDR_W-1:0] head_pc_o,
    output logic [DATA_W-1:0] head_inst_o,
    output logic [CW-1:0]     count_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [DATA_W-1:0] inst_q [DEPTH];
    logic [AW-1:0]     wr_q;
    logic [AW-1:0]     rd_q;
    logic [CW-1:0]     cnt_q;
    logic              w_wr;
    logic              w_rd;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == c_depth);
    assign w_rd    = pop_i && !empty_o;
    // A push into a full queue is legal only when the head leaves in the same cycle.
    assign w_wr    = push_i && (!full_o || w_rd);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (en_i) begin
            if (flush_i) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (w_wr) begin
                    pc_q[wr_q]   <= push_pc_i;
                    inst_q[wr_q] <= push_inst_i;
                    wr_q         <= wr_q + AW'(1);
                end
                if (w_rd) begin
                    rd_q <= rd_q + AW'(1);
                end
                cnt_q <= cnt_q + CW'(w_wr) - CW'(w_rd);
            end
        end
    end

    assign head_pc_o   = pc_q[rd_q];
    assign head_inst_o = inst_q[rd_q];
    assign count_o     = cnt_q;

endmodule

`default_nettype wire

// File: rtl/if_fetch.sv
// ============================================================================
// Module : if_fetch
// Brief  : Instruction-fetch front end: PC generation, controller reads,
//          redirect/drop handling and a small instruction queue to ID.
//          Optional IF_PERF_CNT_EN adds push / discarded-completion counters.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch
    import if_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                QDEPTH   = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    if_fetch_if.master        bus
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_o,
    output logic [31:0]       perf_drop_o
`endif
);

    localparam int            CW      = $clog2(QDEPTH + 1);
    localparam logic [CW-1:0] c_depth = CW'(QDEPTH);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              drop_q, drop_d;

    logic              w_accept;
    logic              w_done;
    logic              w_push;
    logic              w_pop;
    logic              w_discard;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic [CW-1:0]     w_count_after;
    logic [ADDR_W-1:0] w_redirect_pc;

    assign w_redirect_pc = redirect_pc_i & ~ADDR_W'(INST_BYTES - 1);

    // Completions outside WAIT belong to the MEM stage.
    assign w_done        = (state_q == WAIT) && bus.ctrl_done_i;
    assign w_accept      = (state_q == REQ) && !bus.mem_req_i && !bus.ctrl_busy_i;
    assign w_pop         = !w_empty && !bus.stall_i && !redirect_i;
    assign w_push        = w_done && !drop_q && !redirect_i;
    assign w_discard     = w_done && (drop_q || redirect_i);
    assign w_count_after = w_count + CW'(w_push) - CW'(w_pop);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        drop_d   = drop_q;
        case (state_q)
            IDLE: begin
                if (redirect_i) begin
                    pc_d = w_redirect_pc;
                end else if (!w_full) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirect_i) begin
                    pc_d    = w_redirect_pc;
                    state_d = IDLE;
                end else if (w_accept) begin
                    req_pc_d = pc_q;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (redirect_i) begin
                    pc_d = w_redirect_pc;
                    if (bus.ctrl_done_i) begin
                        drop_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (bus.ctrl_done_i) begin
                    drop_d = 1'b0;
                    if (!drop_q) begin
                        pc_d = req_pc_q + ADDR_W'(INST_BYTES);
                    end
                    state_d = (w_count_after < c_depth) ? REQ : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            drop_q   <= 1'b0;
        end else if (rdy) begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            drop_q   <= drop_d;
        end
    end

    fetch_queue #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (QDEPTH),
        .CW     (CW)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .en_i        (rdy),
        .flush_i     (redirect_i),
        .push_i      (w_push),
        .pop_i       (w_pop),
        .push_pc_i   (req_pc_q),
        .push_inst_i (bus.ctrl_data_i),
        .head_pc_o   (bus.id_pc_o),
        .head_inst_o (bus.id_inst_o),
        .count_o     (w_count),
        .full_o      (w_full),
        .empty_o     (w_empty)
    );

    assign bus.if_re_o    = (state_q == REQ);
    assign bus.if_addr_o  = pc_q;
    assign bus.id_valid_o = !w_empty;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_drop_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_q <= '0;
            perf_drop_q  <= '0;
        end else if (rdy) begin
            if (w_push && (perf_fetch_q != '1)) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (w_discard && (perf_drop_q != '1)) begin
                perf_drop_q <= perf_drop_q + 32'd1;
            end
        end
    end

    assign perf_fetch_o = perf_fetch_q;
    assign perf_drop_o  = perf_drop_q;
`else
    logic w_unused_discard;
    assign w_unused_discard = w_discard;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_fetch.sv
// ============================================================================
// Module : tb_if_fetch
// Brief  : Scoreboard bench for if_fetch with a behavioural memory controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_if_fetch;
    import if_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int QDEPTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b1;
    logic        mem_req = 1'b0;
    logic        busy = 1'b0;
    logic        resp_done = 1'b0;
    logic [31:0] resp_data = '0;
    logic        foreign_done = 1'b0;
    logic [31:0] foreign_data = '0;

    int          checks = 0;
    int          errors = 0;
    int          acc_cnt = 0;
    int          lat = 1;
    int          cnt = 0;
    logic [31:0] next_data = 32'h0000_0013;
    logic [31:0] pend_data = '0;

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];

    if_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_drop;
`endif

    if_fetch #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .QDEPTH   (QDEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .bus           (bus)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_o  (perf_fetch),
        .perf_drop_o   (perf_drop)
`endif
    );

    assign bus.mem_req_i   = mem_req;
    assign bus.ctrl_busy_i = busy;
    assign bus.stall_i     = stall;
    assign bus.ctrl_done_i = resp_done | foreign_done;
    assign bus.ctrl_data_i = foreign_done ? foreign_data : resp_data;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Controller model: accepts, then pulses done `lat` cycles later; frozen by rdy.
    always @(negedge clk) begin
        resp_done = 1'b0;
        if (!rst) begin
            cnt = 0;
        end else if (rdy) begin
            if (cnt != 0) begin
                cnt--;
                if (cnt == 0) begin
                    resp_done = 1'b1;
                    resp_data = pend_data;
                end
            end
            if (bus.if_re_o && !mem_req && !busy && !redirect) begin
                acc_cnt++;
                if (addr_q.size() != 0) chk("if_addr", bus.if_addr_o, addr_q.pop_front());
                cnt       = lat;
                pend_data = next_data;
            end
        end
    end

    // ID-side monitor: every consumed head is compared with the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst && rdy && bus.id_valid_o && !stall && !redirect) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_id: got pc %h inst %h expected none", bus.id_pc_o, bus.id_inst_o);
            end else begin
                e = exp_q.pop_front();
                chk("id_pc", bus.id_pc_o, e.pc);
                chk("id_inst", bus.id_inst_o, e.inst);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input logic [31:0] pc, input logic [31:0] inst);
        exp_t e;
        e.pc   = pc;
        e.inst = inst;
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input logic st, input logic mr);
        rst          = 1'b0;
        stall        = st;
        mem_req      = mr;
        redirect     = 1'b0;
        rdy          = 1'b1;
        foreign_done = 1'b0;
        lat          = 1;
        next_data    = 32'h0000_0013;
        acc_cnt      = 0;
        exp_q.delete();
        addr_q.delete();
        @(negedge clk);
        chk("rst_if_re", {31'b0, bus.if_re_o}, 32'd0);
        chk("rst_if_addr", bus.if_addr_o, 32'h0);
        chk("rst_id_valid", {31'b0, bus.id_valid_o}, 32'd0);
        chk("rst_id_pc", bus.id_pc_o, 32'h0);
        chk("rst_id_inst", bus.id_inst_o, 32'h0);
        tick();
        rst = 1'b1;
    endtask

    task automatic wait_acc(input int n, input string name);
        int k;
        k = 0;
        while (acc_cnt < n && k < 100) begin
            tick();
            k++;
        end
        if (acc_cnt < n) begin
            checks++;
            errors++;
            $display("FAIL %s_accept_timeout: got %0d accepts expected %0d", name, acc_cnt, n);
        end
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            tick();
            k++;
        end
        stall = 1'b1;
        checks++;
        if (exp_q.size() != 0 || addr_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d outputs and %0d addresses outstanding expected 0",
                     name, exp_q.size(), addr_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        // 1: free-running sequential fetch
        do_reset(1'b0, 1'b0);
        addr_q.push_back(32'h0); addr_q.push_back(32'h4); addr_q.push_back(32'h8);
        expect_out(32'h0, 32'h13); expect_out(32'h4, 32'h13); expect_out(32'h8, 32'h13);
        drain("t1");

        // 2: stall fills the queue, then rdy=0 freezes pops
        do_reset(1'b1, 1'b0);
        addr_q.push_back(32'h0); addr_q.push_back(32'h4); addr_q.push_back(32'h8);
        repeat (10) tick();
        chk("t2_if_re", {31'b0, bus.if_re_o}, 32'd0);
        chk("t2_id_valid", {31'b0, bus.id_valid_o}, 32'd1);
        chk("t2_id_pc", bus.id_pc_o, 32'h0);
        rdy   = 1'b0;
        stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_frozen_pc", bus.id_pc_o, 32'h0);
        end
        expect_out(32'h0, 32'h13); expect_out(32'h4, 32'h13); expect_out(32'h8, 32'h13);
        rdy = 1'b1;
        drain("t2");

        // 3: MEM owns the controller; foreign done ignored
        do_reset(1'b1, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            foreign_done = (i == 1);
            foreign_data = 32'hBAD0_BAD0;
            tick();
            chk("t3_if_re", {31'b0, bus.if_re_o}, 32'd1);
            chk("t3_if_addr", bus.if_addr_o, 32'h0);
            chk("t3_id_valid", {31'b0, bus.id_valid_o}, 32'd0);
        end
        foreign_done = 1'b0;
        mem_req      = 1'b0;
        stall        = 1'b0;
        addr_q.push_back(32'h0); addr_q.push_back(32'h4);
        expect_out(32'h0, 32'h13); expect_out(32'h4, 32'h13);
        drain("t3");

        // 4: redirect while a slow read is in flight
        do_reset(1'b1, 1'b0);
        lat       = 4;
        next_data = 32'hDEAD_BEEF;
        addr_q.push_back(32'h0); addr_q.push_back(32'h100);
        wait_acc(1, "t4a");
        lat         = 1;
        next_data   = 32'h0000_0013;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        redirect = 1'b0;
        wait_acc(2, "t4b");
        chk("t4_id_valid", {31'b0, bus.id_valid_o}, 32'd0);
        addr_q.push_back(32'h104);
        expect_out(32'h100, 32'h13); expect_out(32'h104, 32'h13);
        stall = 1'b0;
        drain("t4");

        // 5a: redirect coincides with done
        do_reset(1'b1, 1'b0);
        addr_q.push_back(32'h0); addr_q.push_back(32'h200);
        wait_acc(1, "t5a");
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        chk("t5a_if_re", {31'b0, bus.if_re_o}, 32'd0);
        chk("t5a_id_valid", {31'b0, bus.id_valid_o}, 32'd0);
        wait_acc(2, "t5a2");
        chk("t5a_id_valid2", {31'b0, bus.id_valid_o}, 32'd0);
        addr_q.push_back(32'h204);
        expect_out(32'h200, 32'h13); expect_out(32'h204, 32'h13);
        stall = 1'b0;
        drain("t5a");

        // 5b: redirect while held in REQ
        do_reset(1'b1, 1'b1);
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        tick();
        redirect = 1'b0;
        mem_req  = 1'b0;
        chk("t5b_if_re_gap", {31'b0, bus.if_re_o}, 32'd0);
        addr_q.push_back(32'h300); addr_q.push_back(32'h304);
        tick();
        chk("t5b_if_re", {31'b0, bus.if_re_o}, 32'd1);
        chk("t5b_if_addr", bus.if_addr_o, 32'h300);
        expect_out(32'h300, 32'h13); expect_out(32'h304, 32'h13);
        stall = 1'b0;
        drain("t5b");

        // 6: wrap at top of address space, rdy=0 during WAIT
        do_reset(1'b1, 1'b1);
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        mem_req  = 1'b0;
        lat      = 3;
        addr_q.push_back(32'hFFFF_FFFC); addr_q.push_back(32'h0);
        wait_acc(1, "t6");
        lat = 1;
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_frz_if_re", {31'b0, bus.if_re_o}, 32'd0);
            chk("t6_frz_addr", bus.if_addr_o, 32'hFFFF_FFFC);
            chk("t6_frz_valid", {31'b0, bus.id_valid_o}, 32'd0);
        end
        rdy = 1'b1;
        expect_out(32'hFFFF_FFFC, 32'h13); expect_out(32'h0, 32'h13);
        stall = 1'b0;
        drain("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
